uart_alu_bridge: RTL and testbench

//  Parametrised UART<->ALU frame bridge between uart_rx/uart_tx and the ALU.

---
 rtl/uart_alu_bridge_pkg.sv | 24 ++
 rtl/uart_alu_bridge_if.sv | 30 +++
 rtl/uart_alu_bridge_packer.sv | 32 +++
 rtl/uart_alu_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_uart_alu_bridge.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_bridge_pkg.sv
// Package uart_bridge_pkg: shared definitions for the UART<->ALU frame bridge.
//   state_t : bridge FSM states
//   nb_of   : bytes per field, ceil(width / 8)
//   cnt_w   : counter width able to hold 0..n (at least 1 bit)
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_WAIT_ALU,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    function automatic int unsigned nb_of(input int unsigned w);
        return (w + 7) / 8;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_alu_bridge_if.sv
// Interface uart_alu_bridge_if: UART handshake and ALU operand/result bundle.
//   slave  : bridge side (consumes i_*, drives o_*)
//   master : environment side (uart_rx/uart_tx/ALU; drives i_*, consumes o_*)
// Parameters DATA_W / OP_W must match the bridge instance.
interface uart_alu_bridge_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 6
);
    logic              i_rx_done;
    logic [7:0]        i_rx;
    logic              i_tx_done;
    logic [DATA_W-1:0] i_alu_result;
    logic              o_tx_start;
    logic [7:0]        o_tx;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [OP_W-1:0]   o_alu_opcode;
    logic              o_busy;
    logic              o_frame_err;

    modport slave (
        input  i_rx_done, i_rx, i_tx_done, i_alu_result,
        output o_tx_start, o_tx, o_alu_a, o_alu_b, o_alu_opcode, o_busy, o_frame_err
    );

    modport master (
        output i_rx_done, i_rx, i_tx_done, i_alu_result,
        input  o_tx_start, o_tx, o_alu_a, o_alu_b, o_alu_opcode, o_busy, o_frame_err
    );
endinterface

// File: rtl/uart_alu_bridge_packer.sv
// Module uart_byte_packer: combinational byte insert into a multi-byte field.
//   field_i : current field value (DATA_W bits)
//   idx     : byte index, 0 = least significant byte
//   byte_i  : byte to insert
//   field_o : field with byte idx replaced; bits above DATA_W are discarded
module uart_byte_packer
    import uart_bridge_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned NB     = nb_of(DATA_W),
    localparam int unsigned CNT_W  = cnt_w(NB)
) (
    input  logic [DATA_W-1:0] field_i,
    input  logic [CNT_W-1:0]  idx,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] field_o
);
    localparam int unsigned PAD_W = NB * 8;

    logic [PAD_W-1:0] padded;

    always_comb begin
        padded               = '0;
        padded[DATA_W-1:0]   = field_i;
        for (int unsigned i = 0; i < NB; i++) begin
            if (idx == CNT_W'(i)) begin
                padded[i*8 +: 8] = byte_i;
            end
        end
        field_o = padded[DATA_W-1:0];
    end
endmodule

// File: rtl/uart_alu_bridge.sv
// Module uart_alu_bridge: assembles operand A, operand B and an opcode from
// received UART bytes (LSB byte first), waits ALU_LAT cycles for the ALU, then
// sends the result back one byte per uart_tx handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_alu_bridge_if.slave (rx/tx handshakes, ALU operands/result,
//          busy and frame-error status)
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to abort a partial frame
// after TIMEOUT_CYC idle cycles between received bytes (o_frame_err pulse).
module uart_alu_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OP_W        = 6,
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst,
    uart_alu_bridge_if.slave bus
);
    localparam int unsigned NB    = nb_of(DATA_W);
    localparam int unsigned PAD_W = NB * 8;
    localparam int unsigned CNT_W = cnt_w(NB);
    localparam int unsigned LAT_W = cnt_w(ALU_LAT);

    if (DATA_W < 1 || OP_W < 1 || OP_W > 8 || ALU_LAT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("uart_alu_bridge: illegal parameter value");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] a_q, a_d, a_ins;
    logic [DATA_W-1:0] b_q, b_d, b_ins;
    logic [OP_W-1:0]   op_q, op_d;
    logic [PAD_W-1:0]  res_q, res_d;
    logic [7:0]        tx_q, tx_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;

    uart_byte_packer #(.DATA_W(DATA_W)) u_pack_a (
        .field_i (a_q),
        .idx     (cnt_q),
        .byte_i  (bus.i_rx),
        .field_o (a_ins)
    );

    uart_byte_packer #(.DATA_W(DATA_W)) u_pack_b (
        .field_i (b_q),
        .idx     (cnt_q),
        .byte_i  (bus.i_rx),
        .field_o (b_ins)
    );

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned IDLE_W = cnt_w(TIMEOUT_CYC);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        tx_d    = tx_q;
        start_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_GET_A: begin
                if (bus.i_rx_done) begin
                    a_d = a_ins;
                    if (cnt_q == '0) begin
                        busy_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_GET_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GET_B: begin
                if (bus.i_rx_done) begin
                    b_d = b_ins;
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_GET_OP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GET_OP: begin
                if (bus.i_rx_done) begin
                    op_d    = bus.i_rx[OP_W-1:0];
                    lat_d   = '0;
                    state_d = ST_WAIT_ALU;
                end
            end
            ST_WAIT_ALU: begin
                if (lat_q == LAT_W'(ALU_LAT - 1)) begin
                    res_d   = PAD_W'(bus.i_alu_result);
                    state_d = ST_SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_SEND: begin
                tx_d    = res_q[7:0];
                start_d = 1'b1;
                res_d   = res_q >> 8;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    if (cnt_q < CNT_W'(NB)) begin
                        state_d = ST_SEND;
                    end else begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ST_GET_A;
                    end
                end
            end
            default: state_d = ST_GET_A;
        endcase

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Abort only fires on cycles without a byte, so it never collides with
        // the field writes above.
        err_d  = 1'b0;
        idle_d = '0;
        if ((state_q == ST_GET_A && cnt_q != '0) ||
            state_q == ST_GET_B || state_q == ST_GET_OP) begin
            if (!bus.i_rx_done) begin
                if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_GET_A;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_GET_A;
            cnt_q   <= '0;
            lat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign bus.o_frame_err = err_q;
`else
    assign bus.o_frame_err = 1'b0;
`endif

    assign bus.o_tx_start   = start_q;
    assign bus.o_tx         = tx_q;
    assign bus.o_alu_a      = a_q;
    assign bus.o_alu_b      = b_q;
    assign bus.o_alu_opcode = op_q;
    assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_uart_alu_bridge.sv
// Testbench for uart_alu_bridge: three instances (DATA_W = 16, 8, 12) sharing
// clock and reset. A UART tx responder per instance answers each o_tx_start
// with a delayed i_tx_done and pops the expected byte from a scoreboard queue.
module tb_uart_alu_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned err16 = 0;

    logic [7:0] sb16[$];
    logic [7:0] sb8[$];
    logic [7:0] sb12[$];

    uart_alu_bridge_if #(.DATA_W(16), .OP_W(6)) if16 ();
    uart_alu_bridge_if #(.DATA_W(8),  .OP_W(6)) if8 ();
    uart_alu_bridge_if #(.DATA_W(12), .OP_W(6)) if12 ();

    uart_alu_bridge #(.DATA_W(16), .OP_W(6), .ALU_LAT(2), .TIMEOUT_CYC(50)) dut16 (
        .clk (clk), .rst (rst), .bus (if16)
    );
    uart_alu_bridge #(.DATA_W(8), .OP_W(6), .ALU_LAT(1), .TIMEOUT_CYC(50)) dut8 (
        .clk (clk), .rst (rst), .bus (if8)
    );
    uart_alu_bridge #(.DATA_W(12), .OP_W(6), .ALU_LAT(3), .TIMEOUT_CYC(50)) dut12 (
        .clk (clk), .rst (rst), .bus (if12)
    );

    // Environment ALU: 0x20 add, 0x22 sub, 0x24 and, 0x26 xor.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h26:   return a ^ b;
            default: return 16'h0;
        endcase
    endfunction

    assign if16.i_alu_result = alu_fn(if16.o_alu_a, if16.o_alu_b, if16.o_alu_opcode);
    assign if8.i_alu_result  = 8'(alu_fn(16'(if8.o_alu_a), 16'(if8.o_alu_b), if8.o_alu_opcode));
    assign if12.i_alu_result = 12'(alu_fn(16'(if12.o_alu_a), 16'(if12.o_alu_b), if12.o_alu_opcode));

    always @(negedge clk) if (if16.o_frame_err === 1'b1) err16++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_byte(input int d, input logic [7:0] b);
        @(posedge clk);
        #1;
        case (d)
            16: begin if16.i_rx = b; if16.i_rx_done = 1'b1; end
            8:  begin if8.i_rx  = b; if8.i_rx_done  = 1'b1; end
            default: begin if12.i_rx = b; if12.i_rx_done = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if16.i_rx_done = 1'b0;
        if8.i_rx_done  = 1'b0;
        if12.i_rx_done = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int cyc = 0;
        case (d)
            16: while ((if16.o_busy || sb16.size() != 0) && cyc < 400) begin @(negedge clk); cyc++; end
            8:  while ((if8.o_busy  || sb8.size()  != 0) && cyc < 400) begin @(negedge clk); cyc++; end
            default: while ((if12.o_busy || sb12.size() != 0) && cyc < 400) begin @(negedge clk); cyc++; end
        endcase
        chk($sformatf("frame_done_timeout_%0d", d), 32'(cyc >= 400), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op_byte;
        logic [5:0]  exp_op;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vt[6];

    task automatic send16(input vec_t v);
        sb16.push_back(v.exp_res[7:0]);
        sb16.push_back(v.exp_res[15:8]);
        rx_byte(16, v.a[7:0]);
        rx_byte(16, v.a[15:8]);
        rx_byte(16, v.b[7:0]);
        rx_byte(16, v.b[15:8]);
        rx_byte(16, v.op_byte);
    endtask

    task automatic finish16(input vec_t v, input string tag);
        wait_done(16);
        @(negedge clk);
        chk({tag, "_a"},    32'(if16.o_alu_a),      32'(v.a));
        chk({tag, "_b"},    32'(if16.o_alu_b),      32'(v.b));
        chk({tag, "_op"},   32'(if16.o_alu_opcode), 32'(v.exp_op));
        chk({tag, "_busy"}, 32'(if16.o_busy),       32'd0);
    endtask

    // tx responders: check byte, single-cycle start, stable o_tx, no extra start.
    initial begin : resp16
        logic [7:0] held;
        logic       extra;
        forever begin
            @(negedge clk);
            if (if16.o_tx_start === 1'b1) begin
                held = if16.o_tx;
                if (sb16.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx16_unexpected: got 0x%0h expected none", if16.o_tx);
                end else begin
                    chk("tx16_byte", 32'(if16.o_tx), 32'(sb16.pop_front()));
                end
                extra = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    extra = extra | if16.o_tx_start;
                end
                chk("tx16_no_double_start", 32'(extra), 32'd0);
                chk("tx16_hold", 32'(if16.o_tx), 32'(held));
                @(posedge clk); #1 if16.i_tx_done = 1'b1;
                @(posedge clk); #1 if16.i_tx_done = 1'b0;
            end
        end
    end

    initial begin : resp8
        forever begin
            @(negedge clk);
            if (if8.o_tx_start === 1'b1) begin
                if (sb8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx8_unexpected: got 0x%0h expected none", if8.o_tx);
                end else begin
                    chk("tx8_byte", 32'(if8.o_tx), 32'(sb8.pop_front()));
                end
                repeat (3) @(posedge clk);
                #1 if8.i_tx_done = 1'b1;
                @(posedge clk); #1 if8.i_tx_done = 1'b0;
            end
        end
    end

    initial begin : resp12
        forever begin
            @(negedge clk);
            if (if12.o_tx_start === 1'b1) begin
                if (sb12.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx12_unexpected: got 0x%0h expected none", if12.o_tx);
                end else begin
                    chk("tx12_byte", 32'(if12.o_tx), 32'(sb12.pop_front()));
                end
                repeat (3) @(posedge clk);
                #1 if12.i_tx_done = 1'b1;
                @(posedge clk); #1 if12.i_tx_done = 1'b0;
            end
        end
    end

    initial begin : main
        vec_t tv;
        int   cyc;

        if16.i_rx_done = 1'b0; if16.i_rx = '0; if16.i_tx_done = 1'b0;
        if8.i_rx_done  = 1'b0; if8.i_rx  = '0; if8.i_tx_done  = 1'b0;
        if12.i_rx_done = 1'b0; if12.i_rx = '0; if12.i_tx_done = 1'b0;

        vt[0] = '{16'h1234, 16'h5678, 8'h20, 6'h20, 16'h68AC};
        vt[1] = '{16'hFFFF, 16'h0001, 8'h20, 6'h20, 16'h0000};
        vt[2] = '{16'h00F0, 16'h0F0F, 8'h26, 6'h26, 16'h0FFF};
        vt[3] = '{16'h8001, 16'h0002, 8'h22, 6'h22, 16'h7FFF};
        vt[4] = '{16'h0100, 16'h0200, 8'hE0, 6'h20, 16'h0300};
        vt[5] = '{16'hF0F0, 16'hFF00, 8'h24, 6'h24, 16'hF000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a",     32'(if16.o_alu_a),      32'd0);
        chk("rst_b",     32'(if16.o_alu_b),      32'd0);
        chk("rst_op",    32'(if16.o_alu_opcode), 32'd0);
        chk("rst_busy",  32'(if16.o_busy),       32'd0);
        chk("rst_tx",    32'(if16.o_tx),         32'd0);
        chk("rst_start", 32'(if16.o_tx_start),   32'd0);
        chk("rst_err",   32'(if16.o_frame_err),  32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Table-driven frames on the 16-bit instance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_busy_idle", i), 32'(if16.o_busy), 32'd0);
            sb16.push_back(vt[i].exp_res[7:0]);
            sb16.push_back(vt[i].exp_res[15:8]);
            rx_byte(16, vt[i].a[7:0]);
            chk($sformatf("v%0d_busy_rise", i), 32'(if16.o_busy), 32'd1);
            rx_byte(16, vt[i].a[15:8]);
            rx_byte(16, vt[i].b[7:0]);
            rx_byte(16, vt[i].b[15:8]);
            rx_byte(16, vt[i].op_byte);
            finish16(vt[i], $sformatf("v%0d", i));
        end

        // 8-bit instance: 5 + 3 -> single tx byte 0x08
        sb8.push_back(8'h08);
        rx_byte(8, 8'h05);
        rx_byte(8, 8'h03);
        rx_byte(8, 8'h20);
        wait_done(8);
        chk("d8_a",  32'(if8.o_alu_a),      32'h05);
        chk("d8_b",  32'(if8.o_alu_b),      32'h03);
        chk("d8_op", 32'(if8.o_alu_opcode), 32'h20);

        // 12-bit instance: top-byte bits above bit 11 discarded; 0xFFF ^ 0x543 = 0xABC
        sb12.push_back(8'hBC);
        sb12.push_back(8'h0A);
        rx_byte(12, 8'hFF);
        rx_byte(12, 8'hFF);
        rx_byte(12, 8'h43);
        rx_byte(12, 8'hF5);
        rx_byte(12, 8'h26);
        wait_done(12);
        chk("d12_a", 32'(if12.o_alu_a), 32'hFFF);
        chk("d12_b", 32'(if12.o_alu_b), 32'h543);

        // rx byte during WAIT_TX is dropped
        send16(vt[0]);
        cyc = 0;
        while (if16.o_tx_start !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("drop_start_timeout", 32'(cyc >= 100), 32'd0);
        rx_byte(16, 8'h99);
        finish16(vt[0], "drop");
        send16(vt[2]);
        finish16(vt[2], "after_drop");

        // Reset while in GET_B
        rx_byte(16, 8'h34);
        rx_byte(16, 8'h12);
        rx_byte(16, 8'h78);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_a",    32'(if16.o_alu_a),      32'd0);
        chk("midrst_b",    32'(if16.o_alu_b),      32'd0);
        chk("midrst_op",   32'(if16.o_alu_opcode), 32'd0);
        chk("midrst_busy", 32'(if16.o_busy),       32'd0);
        chk("midrst_tx",   32'(if16.o_tx),         32'd0);
        @(posedge clk); #1 rst = 1'b1;
        send16(vt[0]);
        finish16(vt[0], "post_rst");

        // Inter-byte idle gap
        tv = '{16'h0011, 16'h0022, 8'h20, 6'h20, 16'h0033};
        err16 = 0;
        rx_byte(16, 8'h11);
        repeat (60) @(negedge clk);
`ifdef UART_BRIDGE_TIMEOUT_EN
        chk("tmo_err_pulses", 32'(err16),        32'd1);
        chk("tmo_busy",       32'(if16.o_busy),  32'd0);
        chk("tmo_a_partial",  32'(if16.o_alu_a), 32'h1211);
        send16(tv);
        finish16(tv, "after_tmo");
`else
        chk("idle_no_err", 32'(err16),       32'd0);
        chk("idle_busy",   32'(if16.o_busy), 32'd1);
        sb16.push_back(tv.exp_res[7:0]);
        sb16.push_back(tv.exp_res[15:8]);
        rx_byte(16, tv.a[15:8]);
        rx_byte(16, tv.b[7:0]);
        rx_byte(16, tv.b[15:8]);
        rx_byte(16, tv.op_byte);
        finish16(tv, "idle_resume");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
